// File: rtl/tc_operand_loader_pkg.sv
// Shared constants and types for the tensor-core operand loader.
// Element widths alias the project-wide format defines; defaults are
// supplied here when the including build does not provide them.
`ifndef XLEN_FP9E5M3
`define XLEN_FP9E5M3 9
`endif
`ifndef XLEN_FP8
`define XLEN_FP8 8
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 5
`endif

package tc_operand_loader_pkg;

    localparam int SHAPE_M  = 8;
    localparam int SHAPE_K  = 8;
    localparam int SHAPE_N  = 8;
    localparam int ELEM_W   = `XLEN_FP9E5M3;
    localparam int C_W      = `XLEN_FP8;
    localparam int WARP_W   = `DEPTH_WARP;

    // One beat carries a full A row / B column, or a C row in its low bits.
    localparam int ROW_AB_W = SHAPE_K * ELEM_W;
    localparam int ROW_C_W  = SHAPE_N * C_W;

    // Phase lengths in beats, and the counter wide enough for the longest.
    localparam int LEN_A    = SHAPE_M;
    localparam int LEN_B    = SHAPE_N;
    localparam int LEN_C    = SHAPE_M;
    localparam int LEN_MAX  = (SHAPE_M > SHAPE_N) ? SHAPE_M : SHAPE_N;
    localparam int CNT_W    = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        LOAD_C = 2'd2,
        ISSUE  = 2'd3
    } tc_state_e;

    // Per-tile control captured with the first A beat.
    typedef struct packed {
        logic [2:0]        rm;
        logic [4:0]        type_ab;
        logic [2:0]        type_ab_sub;
        logic [4:0]        type_cd;
        logic [7:0]        reg_idxw;
        logic [WARP_W-1:0] warpid;
    } tc_ctrl_t;

endpackage

// File: rtl/tc_operand_loader_if.sv
// Beat-side and array-side signals of the operand loader.
// slave: the loader itself; master: the register-read path / MMA array side.
interface tc_operand_loader_if;
    import tc_operand_loader_pkg::*;

    logic                        beat_valid_i;
    logic                        beat_ready_o;
    logic [ROW_AB_W-1:0]         beat_data_i;
    logic                        abort_i;

    logic [2:0]                  rm_i;
    logic [4:0]                  type_ab_i;
    logic [2:0]                  type_ab_sub_i;
    logic [4:0]                  type_cd_i;
    logic [7:0]                  reg_idxw_i;
    logic [WARP_W-1:0]           warpid_i;
    logic                        czero_i;

    logic [SHAPE_M*ROW_AB_W-1:0] a_o;
    logic [SHAPE_N*ROW_AB_W-1:0] b_o;
    logic [SHAPE_M*ROW_C_W-1:0]  c_o;

    logic [2:0]                  rm_o;
    logic [4:0]                  type_ab_o;
    logic [2:0]                  type_ab_sub_o;
    logic [4:0]                  type_cd_o;
    logic [7:0]                  reg_idxw_o;
    logic [WARP_W-1:0]           warpid_o;

    logic                        out_valid_o;
    logic                        out_ready_i;

    modport slave (
        input  beat_valid_i, beat_data_i, abort_i,
        input  rm_i, type_ab_i, type_ab_sub_i, type_cd_i, reg_idxw_i, warpid_i, czero_i,
        input  out_ready_i,
        output beat_ready_o, a_o, b_o, c_o,
        output rm_o, type_ab_o, type_ab_sub_o, type_cd_o, reg_idxw_o, warpid_o,
        output out_valid_o
    );

    modport master (
        output beat_valid_i, beat_data_i, abort_i,
        output rm_i, type_ab_i, type_ab_sub_i, type_cd_i, reg_idxw_i, warpid_i, czero_i,
        output out_ready_i,
        input  beat_ready_o, a_o, b_o, c_o,
        input  rm_o, type_ab_o, type_ab_sub_o, type_cd_o, reg_idxw_o, warpid_o,
        input  out_valid_o
    );

endinterface

// File: rtl/tc_tile_regfile.sv
// Packed tile register with indexed whole-row write.
// Row r occupies bits [(r+1)*ROW_W-1 : r*ROW_W] of tile_o.
module tc_tile_regfile #(
    parameter int ROWS  = 8,
    parameter int ROW_W = 72,
    parameter int IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [ROW_W-1:0]      row_i,
    output logic [ROWS*ROW_W-1:0] tile_o
);

    logic [ROWS-1:0][ROW_W-1:0] tile_q, tile_d;

    // Replace the addressed row, hold all others.
    always_comb begin
        tile_d = tile_q;
        if (we_i) begin
            tile_d[idx_i] = row_i;
        end
    end

    // Tile storage; cleared only by reset, never after issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_q <= '0;
        end else begin
            tile_q <= tile_d;
        end
    end

    assign tile_o = tile_q;

endmodule

// File: rtl/tc_operand_loader.sv
// Tensor-core operand loader: collects A rows, B columns and C rows one
// beat at a time, then presents the whole tile to the MMA array.
// Optional feature macro: TC_LOADER_CZERO_EN (skip C load, drive C as zero).
module tc_operand_loader
    import tc_operand_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    tc_operand_loader_if.slave bus
);

    tc_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    tc_ctrl_t          ctrl_q, ctrl_d;

    logic              beat_acc;
    logic              first_a;
    logic              skip_c;
    logic [SHAPE_M*ROW_C_W-1:0] c_tile;

    // Ready/valid are pure state decodes so they never glitch on inputs.
    assign bus.beat_ready_o = (state_q != ISSUE);
    assign bus.out_valid_o  = (state_q == ISSUE);

    // Abort drops any beat offered in the same cycle.
    assign beat_acc = bus.beat_valid_i & bus.beat_ready_o & ~bus.abort_i;
    assign first_a  = beat_acc && (state_q == LOAD_A) && (cnt_q == '0);

`ifdef TC_LOADER_CZERO_EN
    logic czero_q, czero_d;

    // Zero-C request follows the tile control: captured on the first A beat.
    always_comb begin
        czero_d = czero_q;
        if (first_a) begin
            czero_d = bus.czero_i;
        end
    end

    // Zero-C flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            czero_q <= 1'b0;
        end else begin
            czero_q <= czero_d;
        end
    end

    assign skip_c  = czero_q;
    assign bus.c_o = czero_q ? '0 : c_tile;
`else
    logic unused_czero;
    assign unused_czero = bus.czero_i;
    assign skip_c       = 1'b0;
    assign bus.c_o      = c_tile;
`endif

    // Phase sequencing and beat counting; abort overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.abort_i) begin
            state_d = LOAD_A;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (beat_acc) begin
                        if (cnt_q == CNT_W'(LEN_A - 1)) begin
                            state_d = LOAD_B;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (beat_acc) begin
                        if (cnt_q == CNT_W'(LEN_B - 1)) begin
                            state_d = skip_c ? ISSUE : LOAD_C;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                LOAD_C: begin
                    if (beat_acc) begin
                        if (cnt_q == CNT_W'(LEN_C - 1)) begin
                            state_d = ISSUE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (bus.out_ready_i) begin
                        state_d = LOAD_A;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tile control is taken from the first A beat only.
    always_comb begin
        ctrl_d = ctrl_q;
        if (first_a) begin
            ctrl_d.rm          = bus.rm_i;
            ctrl_d.type_ab     = bus.type_ab_i;
            ctrl_d.type_ab_sub = bus.type_ab_sub_i;
            ctrl_d.type_cd     = bus.type_cd_i;
            ctrl_d.reg_idxw    = bus.reg_idxw_i;
            ctrl_d.warpid      = bus.warpid_i;
        end
    end

    // Control field register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.rm_o          = ctrl_q.rm;
    assign bus.type_ab_o     = ctrl_q.type_ab;
    assign bus.type_ab_sub_o = ctrl_q.type_ab_sub;
    assign bus.type_cd_o     = ctrl_q.type_cd;
    assign bus.reg_idxw_o    = ctrl_q.reg_idxw;
    assign bus.warpid_o      = ctrl_q.warpid;

    tc_tile_regfile #(
        .ROWS  (SHAPE_M),
        .ROW_W (ROW_AB_W),
        .IDX_W (CNT_W)
    ) u_tile_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (beat_acc && (state_q == LOAD_A)),
        .idx_i  (cnt_q),
        .row_i  (bus.beat_data_i),
        .tile_o (bus.a_o)
    );

    tc_tile_regfile #(
        .ROWS  (SHAPE_N),
        .ROW_W (ROW_AB_W),
        .IDX_W (CNT_W)
    ) u_tile_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (beat_acc && (state_q == LOAD_B)),
        .idx_i  (cnt_q),
        .row_i  (bus.beat_data_i),
        .tile_o (bus.b_o)
    );

    tc_tile_regfile #(
        .ROWS  (SHAPE_M),
        .ROW_W (ROW_C_W),
        .IDX_W (CNT_W)
    ) u_tile_c (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (beat_acc && (state_q == LOAD_C)),
        .idx_i  (cnt_q),
        .row_i  (bus.beat_data_i[ROW_C_W-1:0]),
        .tile_o (c_tile)
    );

endmodule
